// File: rtl/proc_pkg.sv
// proc_pkg
// Shared definitions for the 3BC processor front end: the PC sequencer state
// encoding, datapath widths and the fixed program start addresses.
// No ports; imported by pc_sequencer and pc_adder.
package proc_pkg;

   localparam int PC_W  = 10;
   localparam int IDX_W = 8;
   localparam int CNT_W = 16;

   localparam logic [PC_W-1:0] P0_START = 10'd0;
   localparam logic [PC_W-1:0] P1_START = 10'd341;
   localparam logic [PC_W-1:0] P2_START = 10'd682;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      BRANCH = 2'd2,
      DONE   = 2'd3
   } seq_state_t;

   // Program select 3 has no program of its own and aliases program 2.
   function automatic logic [PC_W-1:0] startAddr(input logic [1:0] sel);
      case (sel)
         2'd0:    return P0_START;
         2'd1:    return P1_START;
         default: return P2_START;
      endcase
   endfunction

endpackage

// File: rtl/pc_adder.sv
// pc_adder
// Combinational next-PC adder shared by sequential fetch and branch targets.
// Ports:
//   pc_i      base address
//   offset_i  signed relative offset, already PC_W wide
//   incSel_i  1 = add one (sequential fetch), 0 = add offset_i
//   nextPc_o  sum modulo 2^PC_W
module pc_adder
   import proc_pkg::*;
(
   input  logic [PC_W-1:0] pc_i,
   input  logic [PC_W-1:0] offset_i,
   input  logic            incSel_i,
   output logic [PC_W-1:0] nextPc_o
);

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   logic [PC_W-1:0] addend;

   // Carry out is dropped on purpose, which gives the modulo wrap for free
   // in both directions (1023+1=0, and negative offsets below zero).
   assign addend   = incSel_i ? PC_ONE : offset_i;
   assign nextPc_o = pc_i + addend;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Owns the program counter: launches a program on Start, steps the PC,
// resolves taken branches through the external branch-target LUT (one bubble
// cycle) and signals completion on a halt instruction.
// Ports:
//   Clk, Reset          clock and asynchronous active-low reset
//   Start, ProgSel      launch request and program select (IDLE only)
//   Stall               freeze PC/state while running
//   BranchEn/Taken/Idx  branch info from the decoder
//   HaltInstr           halt instruction from the decoder
//   LutIndex, LutOut    index to and signed offset from the LUT
//   PC, InstrValid      fetch address and its qualifier
//   Busy, Done          activity level and one-cycle completion pulse
//   CycleCount          saturating count of RUN/BRANCH cycles since Start
module pc_sequencer
   import proc_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       ProgSel,
   input  logic             Stall,
   input  logic             BranchEn,
   input  logic             BranchTaken,
   input  logic [IDX_W-1:0] BranchIdx,
   input  logic             HaltInstr,
   output logic [IDX_W-1:0] LutIndex,
   input  logic [PC_W-1:0]  LutOut,
   output logic [PC_W-1:0]  PC,
   output logic             InstrValid,
   output logic             Busy,
   output logic             Done,
   output logic [CNT_W-1:0] CycleCount
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   seq_state_t       state_q;
   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  brPc_q;
   logic [IDX_W-1:0] lutIdx_q;
   logic             done_q;
   logic [CNT_W-1:0] cnt_q;

   logic [PC_W-1:0]  nextPc_d;
   logic [CNT_W-1:0] cnt_d;
   logic             inBranch;

   // In BRANCH the adder computes latched branch PC + LUT offset; in every
   // other state it computes PC+1. The LUT is the only offset source.
   assign inBranch = (state_q == BRANCH);

   pc_adder uAdder (
      .pc_i     (inBranch ? brPc_q : pc_q),
      .offset_i (LutOut),
      .incSel_i (!inBranch),
      .nextPc_o (nextPc_d)
   );

   assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;

   // Sequencer FSM. Done is registered alongside the move into DONE so it is
   // high for exactly the DONE cycle; a reset never produces it.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         brPc_q   <= '0;
         lutIdx_q <= '0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Start) begin
                  pc_q    <= startAddr(ProgSel);
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               cnt_q <= cnt_d;
               if (!Stall) begin
                  if (HaltInstr) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else if (BranchEn && BranchTaken) begin
                     lutIdx_q <= BranchIdx;
                     brPc_q   <= pc_q;
                     state_q  <= BRANCH;
                  end else begin
                     pc_q <= nextPc_d;
                  end
               end
            end
            BRANCH: begin
               cnt_q   <= cnt_d;
               pc_q    <= nextPc_d;
               state_q <= RUN;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign PC         = pc_q;
   assign LutIndex   = lutIdx_q;
   assign Done       = done_q;
   assign CycleCount = cnt_q;
   assign InstrValid = (state_q == RUN);
   assign Busy       = (state_q == RUN) || (state_q == BRANCH);

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 3BC processor: owns the PC, launches programs on a start request, and resolves taken branches by driving the branch-target LUT index and applying the returned signed relative offset to the PC. Sits between the instruction decoder (branch/halt flags) and instruction memory (PC, fetch-valid), with the LUT as its only arithmetic resource. It is the only block that drives the LUT index.

## Interface
- PC_W, 10, PC and LUT offset width
- IDX_W, 8, LUT index width
- P0_START, 0, start address for program select 0
- P1_START, 341, start address for program select 1
- P2_START, 682, start address for program select 2 (select 3 also maps here)
- CNT_W, 16, cycle counter width

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  launch request, sampled only in IDLE
- ProgSel  in  2  program select, sampled with Start
- Stall  in  1  freeze PC and state (RUN only)
- BranchEn  in  1  current instruction is a conditional branch
- BranchTaken  in  1  branch condition true
- BranchIdx  in  IDX_W  LUT entry named by the branch
- HaltInstr  in  1  current instruction is halt
- LutIndex  out  IDX_W  registered index to LUT
- LutOut  in  PC_W  signed relative offset from LUT, combinational on LutIndex
- PC  out  PC_W  fetch address
- InstrValid  out  1  PC is a valid fetch this cycle
- Busy  out  1  state is RUN or BRANCH
- Done  out  1  one-cycle pulse on program completion
- CycleCount  out  CNT_W  cycles spent in RUN/BRANCH since last Start

## Operation
- States: IDLE, RUN, BRANCH, DONE.
- IDLE: InstrValid=0. Start=1 → PC←start address for ProgSel, CycleCount←0, go RUN.
- RUN, Stall=1: PC, state and LutIndex hold; CycleCount still increments.
- RUN, Stall=0, priority order:
  - HaltInstr=1 → go DONE; PC holds.
  - BranchEn & BranchTaken → LutIndex←BranchIdx, latch branch PC, go BRANCH.
  - Otherwise → PC←PC+1.
- BranchEn=1 with BranchTaken=0 is an ordinary PC+1.
- BRANCH: InstrValid=0; PC←latched branch PC + sign-extended LutOut; go RUN. Stall is ignored in BRANCH.
- DONE: Done=1 for exactly one cycle, go IDLE; PC holds the halt address.
- Start outside IDLE is ignored. In DONE, Start is ignored and must be reasserted in IDLE.
- Arithmetic: all PC math is modulo 2^PC_W, so 1023+1=0 and 18+(−459) wraps. CycleCount saturates at all-ones.
- Unprogrammed LUT entries return 1, so a taken branch to an unknown index acts as PC+1 with a one-cycle bubble.

## Timing
- Reset values (asserted asynchronously): state=IDLE, PC=0, LutIndex=0, InstrValid=0, Busy=0, Done=0, CycleCount=0.
- Reset mid-operation, including in BRANCH, aborts immediately to reset values with no Done pulse.
- Start in cycle N → PC=start and InstrValid=1 in cycle N+1.
- Taken branch sampled at edge N → BRANCH in cycle N+1, with LutIndex valid that cycle → target PC and InstrValid=1 in cycle N+2. Penalty is one bubble.
- HaltInstr sampled at edge N → Done=1 in cycle N+1, IDLE in cycle N+2.
- All outputs are registered except Busy and InstrValid, which are decoded from the state register only.

## Structure
- Shared package `proc_pkg`:
  - state enum `seq_state_t` (IDLE, RUN, BRANCH, DONE)
  - PC_W / IDX_W constants
  - program start-address constants
- Sub-module: `pc_adder`, combinational. Inputs: PC, sign-extended offset, increment select. Output: next PC modulo 2^PC_W. Used for both PC+1 and branch targets.
- The LUT itself is instantiated beside this block at top level, not inside it.

## Test plan
- Reset low, then high; Start=1, ProgSel=0 → PC 0,1,2,3 on consecutive cycles; InstrValid=1; Busy=1.
- From ProgSel=1, run to PC=477, then a taken branch with BranchIdx=0 and LUT returning −459 → one cycle with InstrValid=0, then PC=18.
- PC=1023 with no branch → PC=0 next cycle. Branch at PC=5 with offset −10 → PC=1019.
- Stall held 3 cycles at PC=40 → PC stays 40, CycleCount advances by 3. Stall asserted in BRANCH → target still taken.
- HaltInstr=1 and a taken branch together at PC=100 → Done pulses once, PC stays 100, then IDLE. Start asserted during RUN → ignored.
- Reset asserted in the BRANCH cycle → all outputs zero immediately, state IDLE, no Done pulse.
